// File: rtl/switch_confirm_debounce.sv
// Synchronises and debounces the confirm button and 16 DIP switches, producing a sticky
// confirmation flag and a switch value frozen while confirmation is pending. BTN_AUTOREPEAT_EN adds press auto-repeat.
module switch_confirm_debounce #(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int SW_STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES    = 50_000_000,
    parameter int CNT_W            = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic [15:0] switch_raw,
    input  logic        ack,
    output logic [15:0] switch_input,
    output logic        confirmation,
    output logic        btn_level
);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} btn_state_t;

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_MAX = CNT_W'(SW_STABLE_CYCLES - 1);

    btn_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] scnt;
    logic [15:0]      cand;
    logic             btn_meta, btn_s;
    logic [15:0]      sw_meta, sw_s;
    logic             fsm_press_evt;
    logic             press_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            sw_meta  <= '0;
            sw_s     <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
            sw_meta  <= switch_raw;
            sw_s     <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        fsm_press_evt = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (btn_s) state_next = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_MAX) begin
                    state_next    = HELD;
                    cnt_next      = '0;
                    fsm_press_evt = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                cnt_next = '0;
                if (!btn_s) state_next = REL_CHK;
            end
            REL_CHK: begin
                if (btn_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == DB_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign btn_level = (state == HELD) || (state == REL_CHK);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rcnt;
    logic             repeat_hit;

    // Runs only across consecutive HELD cycles; any other state, or re-entry, restarts it.
    assign repeat_hit = (state == HELD) && (state_next == HELD) && (rcnt == RP_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt <= '0;
        end else if ((state == HELD) && (state_next == HELD)) begin
            rcnt <= repeat_hit ? '0 : rcnt + CNT_W'(1);
        end else begin
            rcnt <= '0;
        end
    end

    assign press_evt = fsm_press_evt | repeat_hit;
`else
    localparam int unused_repeat_cycles = REPEAT_CYCLES;

    assign press_evt = fsm_press_evt;
`endif

    // ack is a single-cycle strobe from the CPU read; a press on the same edge wins so it is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            confirmation <= 1'b0;
        end else if (press_evt) begin
            confirmation <= 1'b1;
        end else if (ack) begin
            confirmation <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand         <= '0;
            scnt         <= '0;
            switch_input <= '0;
        end else if (sw_s != cand) begin
            cand <= sw_s;
            scnt <= '0;
        end else begin
            if (scnt != SW_MAX) scnt <= scnt + CNT_W'(1);
            // Frozen while a confirmation is pending so the CPU reads the value present at the press.
            if ((scnt == SW_MAX) && !confirmation) switch_input <= cand;
        end
    end

endmodule

// File: tb/tb_switch_confirm_debounce.sv
// Directed bench for switch_confirm_debounce with short debounce/repeat periods.
// Expectations follow BTN_AUTOREPEAT_EN when the bench is compiled with it.
module tb_switch_confirm_debounce;

    typedef struct {
        logic        btn;
        logic [15:0] sw;
        logic        ack;
        logic        exp_conf;
        logic        exp_level;
        logic [15:0] exp_sw;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        btn_raw;
    logic [15:0] switch_raw;
    logic        ack;
    logic [15:0] switch_input;
    logic        confirmation;
    logic        btn_level;

    int n_vec;
    int n_err;
    logic [15:0] exp_q[$];

    switch_confirm_debounce #(
        .DEBOUNCE_CYCLES (4),
        .SW_STABLE_CYCLES(4),
        .REPEAT_CYCLES   (16),
        .CNT_W           (26)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .switch_raw  (switch_raw),
        .ack         (ack),
        .switch_input(switch_input),
        .confirmation(confirmation),
        .btn_level   (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int e, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d: got %h expected %h", name, e, act, exp);
        end
    endtask

    vec_t tbl[8];

    initial begin
        n_vec = 0;
        n_err = 0;

        // Test 1 table: button held and switches at A5A5 through reset release.
        tbl[0] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[6] = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b1, 16'hA5A5};
        tbl[7] = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b1, 16'hA5A5};

        rst        = 1'b0;
        btn_raw    = 1'b1;
        switch_raw = 16'hA5A5;
        ack        = 1'b0;
        ticks(3);
        check("reset_conf", 0, {15'd0, confirmation}, 16'd0);
        check("reset_level", 0, {15'd0, btn_level}, 16'd0);
        check("reset_sw", 0, switch_input, 16'h0000);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            btn_raw    = tbl[i].btn;
            switch_raw = tbl[i].sw;
            ack        = tbl[i].ack;
            tick();
            check("t1_conf", i + 1, {15'd0, confirmation}, {15'd0, tbl[i].exp_conf});
            check("t1_level", i + 1, {15'd0, btn_level}, {15'd0, tbl[i].exp_level});
            check("t1_sw", i + 1, switch_input, tbl[i].exp_sw);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t1_ack_clear", 9, {15'd0, confirmation}, 16'd0);
        btn_raw = 1'b0;
        ticks(10);
        check("t1_release", 0, {15'd0, btn_level}, 16'd0);

        // Test 2: button bounces every 2 cycles, then held low.
        for (int e = 1; e <= 40; e++) begin
            btn_raw = (e <= 30) ? (((e - 1) / 2) % 2 == 0) : 1'b0;
            tick();
            check("t2_conf", e, {15'd0, confirmation}, 16'd0);
            check("t2_level", e, {15'd0, btn_level}, 16'd0);
        end

        // Test 3: clean 12-cycle press, ack at edge 10, release latency.
        for (int e = 1; e <= 25; e++) begin
            btn_raw = (e <= 12);
            ack     = (e == 10);
            tick();
            check("t3_conf", e, {15'd0, confirmation}, {15'd0, (e >= 7 && e <= 9)});
            check("t3_level", e, {15'd0, btn_level}, {15'd0, (e >= 7 && e <= 18)});
        end
        ack = 1'b0;

        // Test 4: switch value frozen while confirmation is pending.
        switch_raw = 16'h00FF;
        ticks(8);
        check("t4_settled", 0, switch_input, 16'h00FF);
        for (int e = 1; e <= 14; e++) begin
            btn_raw = (e <= 8);
            ack     = (e == 12);
            if (e == 3) switch_raw = 16'hFF00;
            tick();
            check("t4_sw", e, switch_input, (e <= 12) ? 16'h00FF : 16'hFF00);
        end
        ack = 1'b0;
        ticks(10);

        // Test 5: ack on the second press event edge; stray ack while idle.
        for (int e = 1; e <= 30; e++) begin
            btn_raw = (e <= 8) || (e >= 16);
            ack     = (e == 3) || (e == 22) || (e == 26);
            tick();
            check("t5_conf", e, {15'd0, confirmation}, {15'd0, (e >= 7 && e <= 25)});
        end
        ack     = 1'b0;
        btn_raw = 1'b0;
        ticks(10);

        // Test 6: long hold, ack each pulse; scoreboard of press edges.
        exp_q.push_back(16'd7);
`ifdef BTN_AUTOREPEAT_EN
        exp_q.push_back(16'd23);
        exp_q.push_back(16'd39);
`endif
        for (int e = 1; e <= 50; e++) begin
            btn_raw = (e <= 45);
            ack     = confirmation;
            tick();
            if (confirmation) begin
                if (exp_q.size() == 0) begin
                    check("t6_extra_event", e, 16'(e), 16'd0);
                end else begin
                    check("t6_event_edge", e, 16'(e), exp_q.pop_front());
                end
            end
        end
        ack = 1'b0;
        check("t6_missing_events", 50, 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
